// File: rtl/fifo_write_ctr_if.sv
// Producer/consumer-facing signal bundle of the FIFO write controller.
// The master drives the requests; the slave is the controller.
interface fifo_write_ctr_if #(
    parameter int regLength = 8,
    parameter int addrSize  = 3
);
    logic                wEnable;
    logic                rEnable;
    logic                clrOverflow;
    logic [addrSize-1:0] wptr;
    logic [regLength-1:0] regWe;
    logic [addrSize:0]   occupancy;
    logic                fifoEmpty;
    logic                fifoFull;
    logic                afull;
    logic                overflow;

    modport master (
        output wEnable, rEnable, clrOverflow,
        input  wptr, regWe, occupancy,
        input  fifoEmpty, fifoFull, afull, overflow
    );

    modport slave (
        input  wEnable, rEnable, clrOverflow,
        output wptr, regWe, occupancy,
        output fifoEmpty, fifoFull, afull, overflow
    );
endinterface

// File: rtl/fifo_write_ctr.sv
// Write-side controller of the register-file FIFO: write pointer,
// one-hot write strobes, occupancy and registered status flags.
module fifo_write_ctr #(
    parameter int regLength  = 8,
    parameter int addrSize   = 3,
    parameter int afullLevel = 6
) (
    input  logic            clk,
    input  logic            rst,
    fifo_write_ctr_if.slave bus
);
    localparam logic [addrSize-1:0] PtrLast = addrSize'(regLength - 1);
    localparam logic [addrSize:0]   OccFull = (addrSize+1)'(regLength);
    localparam logic [addrSize:0]   OccAf   = (addrSize+1)'(afullLevel);

    logic [addrSize-1:0]  wptr_q, wptr_d;
    logic [addrSize:0]    occ_q, occ_d;
    logic                 empty_q, full_q, afull_q, ovf_q, ovf_d;
    logic                 rd_acc, wr_acc;
    logic [regLength-1:0] we;

    // A full FIFO still accepts a write when a read frees a slot this cycle
    assign rd_acc = bus.rEnable && !empty_q;
    assign wr_acc = bus.wEnable && (!full_q || rd_acc);

    always_comb begin
        we = '0;
        if (wr_acc && !rst)
            we[wptr_q] = 1'b1;
    end

    always_comb begin
        wptr_d = wptr_q;
        if (wr_acc)
            wptr_d = (wptr_q == PtrLast) ? '0 : wptr_q + 1'b1;
    end

    always_comb begin
        occ_d = occ_q;
        if (wr_acc && !rd_acc)
            occ_d = occ_q + 1'b1;
        else if (rd_acc && !wr_acc)
            occ_d = occ_q - 1'b1;
    end

    // Set has priority over a simultaneous clear
    always_comb begin
        ovf_d = ovf_q;
        if (bus.clrOverflow)
            ovf_d = 1'b0;
        if (bus.wEnable && !wr_acc)
            ovf_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            occ_q   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            occ_q   <= occ_d;
            empty_q <= (occ_d == '0);
            full_q  <= (occ_d == OccFull);
            afull_q <= (occ_d >= OccAf);
            ovf_q   <= ovf_d;
        end
    end

    assign bus.wptr      = wptr_q;
    assign bus.regWe     = we;
    assign bus.occupancy = occ_q;
    assign bus.fifoEmpty = empty_q;
    assign bus.fifoFull  = full_q;
    assign bus.afull     = afull_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_fifo_write_ctr.sv
// Directed bench for fifo_write_ctr: fill, overflow, pass-through,
// empty write-with-read and asynchronous reset mid-operation.
module tb_fifo_write_ctr;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    fifo_write_ctr_if #(.regLength(8), .addrSize(3)) bus ();

    fifo_write_ctr #(
        .regLength (8),
        .addrSize  (3),
        .afullLevel(6)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic w, input logic r, input logic c);
        @(negedge clk);
        bus.wEnable     = w;
        bus.rEnable     = r;
        bus.clrOverflow = c;
        #1;
    endtask

    task automatic edge_settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.wEnable     = 1'b0;
        bus.rEnable     = 1'b0;
        bus.clrOverflow = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        edge_settle();

        chk("rst_wptr", bus.wptr, 0);
        chk("rst_occ", bus.occupancy, 0);
        chk("rst_empty", bus.fifoEmpty, 1);
        chk("rst_full", bus.fifoFull, 0);
        chk("rst_afull", bus.afull, 0);
        chk("rst_ovf", bus.overflow, 0);
        chk("rst_we", bus.regWe, 8'h00);

        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            chk($sformatf("fill_we%0d", i), bus.regWe, 32'd1 << i);
            edge_settle();
            chk($sformatf("fill_occ%0d", i), bus.occupancy, i + 1);
            if (i == 4) chk("afull_at5", bus.afull, 0);
            if (i == 5) chk("afull_at6", bus.afull, 1);
            if (i == 6) chk("full_at7", bus.fifoFull, 0);
        end
        chk("fill_full", bus.fifoFull, 1);
        chk("fill_wrap", bus.wptr, 0);
        chk("fill_empty", bus.fifoEmpty, 0);

        drive(1'b1, 1'b0, 1'b0);
        chk("ovf_we", bus.regWe, 8'h00);
        edge_settle();
        chk("ovf_occ", bus.occupancy, 8);
        chk("ovf_wptr", bus.wptr, 0);
        chk("ovf_set", bus.overflow, 1);
        drive(1'b1, 1'b0, 1'b1);
        edge_settle();
        chk("ovf_setwins", bus.overflow, 1);
        drive(1'b0, 1'b0, 1'b0);
        edge_settle();
        chk("ovf_hold", bus.overflow, 1);
        drive(1'b0, 1'b0, 1'b1);
        edge_settle();
        chk("ovf_clr", bus.overflow, 0);

        drive(1'b1, 1'b1, 1'b0);
        chk("pass_we", bus.regWe, 8'h01);
        edge_settle();
        chk("pass_occ", bus.occupancy, 8);
        chk("pass_wptr", bus.wptr, 1);
        chk("pass_ovf", bus.overflow, 0);
        chk("pass_full", bus.fifoFull, 1);

        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 1'b0);
            edge_settle();
        end
        chk("drain_occ", bus.occupancy, 0);
        chk("drain_empty", bus.fifoEmpty, 1);
        chk("drain_afull", bus.afull, 0);
        drive(1'b0, 1'b1, 1'b0);
        edge_settle();
        chk("under_occ", bus.occupancy, 0);

        drive(1'b1, 1'b1, 1'b0);
        chk("ewr_we", bus.regWe, 8'h02);
        edge_settle();
        chk("ewr_occ", bus.occupancy, 1);
        chk("ewr_empty", bus.fifoEmpty, 0);
        chk("ewr_wptr", bus.wptr, 2);

        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            edge_settle();
        end
        chk("pre_rst_occ", bus.occupancy, 5);
        chk("pre_rst_wptr", bus.wptr, 6);

        #2;
        rst = 1'b1;
        #1;
        chk("arst_occ", bus.occupancy, 0);
        chk("arst_wptr", bus.wptr, 0);
        chk("arst_empty", bus.fifoEmpty, 1);
        chk("arst_we", bus.regWe, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_we", bus.regWe, 8'h01);
        edge_settle();
        chk("post_rst_occ", bus.occupancy, 1);
        chk("post_rst_wptr", bus.wptr, 1);
        drive(1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_write_ctr.md
Name: fifo_write_ctr

Overview:
- Write-side controller for the serial block's register-file FIFO; the producer-side counterpart of the FIFO read counter.
- Owns the write pointer and decodes it into per-register write strobes.
- Tracks occupancy from accepted writes and accepted reads, and generates the full, empty, almost-full and sticky overflow flags used by both ends and by the APB status register.

Parameters:
- regLength, 8, number of FIFO registers (depth); must equal 2**addrSize.
- addrSize, 3, pointer width in bits.
- afullLevel, 6, occupancy at or above which afull asserts; range 1..regLength.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wEnable  in  1  producer requests a write this cycle.
- rEnable  in  1  consumer requests a read this cycle (same signal the read counter sees).
- clrOverflow  in  1  single-cycle pulse that clears the overflow flag.
- wptr  out  addrSize  register index the next accepted write targets.
- regWe  out  regLength  one-hot write strobe into the register file; combinational.
- occupancy  out  addrSize+1  number of valid entries, 0..regLength.
- fifoEmpty  out  1  registered; high when occupancy == 0.
- fifoFull  out  1  registered; high when occupancy == regLength.
- afull  out  1  registered; high when occupancy >= afullLevel.
- overflow  out  1  registered sticky; a write was rejected.

Behaviour:
- Reset (async, rst=1), independent of clk:
  - wptr=0, occupancy=0, fifoEmpty=1, fifoFull=0, afull=0, overflow=0.
  - regWe=0 while rst is high.
- Read acceptance: rdAcc = rEnable && !fifoEmpty. This matches the read counter, which does not advance when empty.
- Write acceptance: wrAcc = wEnable && (!fifoFull || rdAcc).
  - Full with simultaneous accepted read: write is accepted (pass-through).
  - Empty with simultaneous read request: read is not accepted; the write is accepted.
- regWe: regWe[wptr] = wrAcc; all other bits 0. Data is captured by the register file on the same edge.
- wptr: advances by 1 on each wrAcc; wraps regLength-1 -> 0. It holds otherwise.
- Occupancy update, next value:
  - wrAcc && !rdAcc: +1
  - rdAcc && !wrAcc: -1
  - both or neither: unchanged
  - Arithmetic is addrSize+1 bits; acceptance rules guarantee no wrap below 0 or above regLength.
- Flags: fifoEmpty, fifoFull and afull are registered, computed from next occupancy. They are valid the cycle after the causing edge and are never derived combinationally from the current inputs.
- Overflow:
  - Set on any cycle with wEnable && !wrAcc.
  - Cleared by clrOverflow.
  - If set and clear occur in the same cycle, set wins.
  - Once set, it holds until cleared or reset.
- Rejected write side effects: wptr, occupancy and regWe are unaffected.
- Reset mid-operation: all state returns to reset values immediately. The first write after rst deasserts targets register 0.
- No state machine beyond the counters. Latency: write accepted at edge N is counted in occupancy and flags after edge N.

Test Plan:
1. Reset then idle -> wptr=0, occupancy=0, fifoEmpty=1, fifoFull=0, afull=0, overflow=0, regWe=8'h00.
2. Eight consecutive wEnable pulses, rEnable=0:
   - regWe sequence 01,02,04,...,80.
   - After the 6th write: afull=1. After the 8th: fifoFull=1, occupancy=8, wptr wrapped to 0.
3. Full, then wEnable=1 alone -> regWe=0, occupancy stays 8, overflow=1 next cycle. Then clrOverflow pulse -> overflow=0.
4. Full with wEnable=1 and rEnable=1 in the same cycle -> write accepted, regWe=01 (wptr=0), occupancy stays 8, wptr=1, overflow stays 0.
5. Empty with wEnable=1 and rEnable=1 -> read rejected, occupancy=1, fifoEmpty=0 next cycle.
6. Occupancy=5, rst asserted asynchronously mid-cycle -> outputs at reset values before the next clk edge. The next write after release strobes regWe=01.
